// File: rtl/copy_expander_if.sv
// Item stream, byte stream and history-buffer port of the copy expander.
// slave is the expander's view; master is the environment that feeds it and owns the buffer.
interface copy_expander_if #(
   parameter int HISTORY_SIZE = 4096
);
   localparam int ADDR_WIDTH = $clog2(HISTORY_SIZE);

   logic                  in_valid;
   logic                  in_ready;
   logic                  in_is_copy;
   logic [7:0]            in_literal;
   logic [ADDR_WIDTH-1:0] in_offset;
   logic [3:0]            in_len_code;

   logic                  out_valid;
   logic                  out_ready;
   logic [7:0]            out_data;

   logic                  hb_wr_en;
   logic [ADDR_WIDTH-1:0] hb_wr_addr;
   logic [7:0]            hb_data_in;
   logic [ADDR_WIDTH-1:0] hb_rd_addr;
   logic [7:0]            hb_data_out;

   modport slave (
      input  in_valid, in_is_copy, in_literal, in_offset, in_len_code,
      input  out_ready, hb_data_out,
      output in_ready, out_valid, out_data,
      output hb_wr_en, hb_wr_addr, hb_data_in, hb_rd_addr
   );

   modport master (
      output in_valid, in_is_copy, in_literal, in_offset, in_len_code,
      output out_ready, hb_data_out,
      input  in_ready, out_valid, out_data,
      input  hb_wr_en, hb_wr_addr, hb_data_in, hb_rd_addr
   );
endinterface

// File: rtl/copy_expander.sv
// LZ-style copy expander: turns literal/copy items into a byte stream and
// mirrors every emitted byte into an external history buffer.
//
// state | meaning
// IDLE  | waiting for an item, in_ready high
// LIT   | presenting the captured literal byte
// COPY  | streaming bytes read back from the history buffer
module copy_expander #(
   parameter int HISTORY_SIZE = 4096
) (
   input  logic           clock,
   input  logic           reset,
   copy_expander_if.slave bus,
   output logic           busy
);
   localparam int HISTORY_ADDR_WIDTH = $clog2(HISTORY_SIZE);
   localparam logic [HISTORY_ADDR_WIDTH-1:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LIT  = 2'd1,
      COPY = 2'd2
   } state_t;

   state_t                        state;
   state_t                        state_next;
   logic [HISTORY_ADDR_WIDTH-1:0] wp;
   logic [HISTORY_ADDR_WIDTH-1:0] rd_ptr;
   logic [4:0]                    remaining;
   logic [7:0]                    lit_reg;
   logic                          accept;
   logic                          xfer;

   assign accept = bus.in_valid && (state == IDLE);
   assign xfer   = (state != IDLE) && bus.out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               state_next = bus.in_is_copy ? COPY : LIT;
            end
         end
         LIT: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         COPY: begin
            if (bus.out_ready && (remaining == 5'd1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Every emitted byte is also written back so later copies (including
   // overlapping ones) can read it one cycle later.
   always_comb begin
      bus.in_ready   = (state == IDLE);
      bus.out_valid  = (state != IDLE);
      bus.out_data   = (state == COPY) ? bus.hb_data_out : lit_reg;
      bus.hb_rd_addr = rd_ptr;
      bus.hb_wr_en   = xfer;
      bus.hb_wr_addr = wp;
      bus.hb_data_in = bus.out_data;
      busy           = (state != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp        <= '0;
         rd_ptr    <= '0;
         remaining <= '0;
         lit_reg   <= '0;
      end else begin
         if (accept && bus.in_is_copy) begin
            // offset 0 wraps to a full-buffer distance, i.e. rd_ptr = wp
            rd_ptr    <= wp - bus.in_offset;
            remaining <= {1'b0, bus.in_len_code} + 5'd3;
         end
         if (accept && !bus.in_is_copy) begin
            lit_reg <= bus.in_literal;
         end
         if (xfer) begin
            wp <= wp + PTR_ONE;
         end
         if (xfer && (state == COPY)) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            remaining <= remaining - 5'd1;
         end
      end
   end
endmodule

// File: tb/tb_copy_expander.sv
// Directed bench for copy_expander: table of items with hand-computed byte
// patterns, plus hand-written backpressure and mid-copy reset sequences.
module tb_copy_expander;
   logic clock;
   logic reset;
   logic busy;

   copy_expander_if #(.HISTORY_SIZE(4096)) bus ();

   copy_expander #(.HISTORY_SIZE(4096)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   logic [7:0] mem [0:4095];

   assign bus.hb_data_out = mem[bus.hb_rd_addr];

   always @(posedge clock) begin
      if (bus.hb_wr_en) mem[bus.hb_wr_addr] <= bus.hb_data_in;
   end

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          rst;
      int          pre;
      bit          is_copy;
      logic [7:0]  lit;
      logic [11:0] off;
      logic [3:0]  len_code;
      int          n;
      logic [63:0] pat;
      logic [11:0] wp_end;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
      chk({tag, "_hb_wr_en"},  {31'd0, bus.hb_wr_en},  32'd0);
      chk({tag, "_busy"},      {31'd0, busy},          32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk_idle("rst_held");
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk_idle("rst_release");
   endtask

   task automatic send_quiet(input logic [7:0] lit);
      bus.in_valid   = 1'b1;
      bus.in_is_copy = 1'b0;
      bus.in_literal = lit;
      @(negedge clock);
      bus.in_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic run_item(input vec_t v, input logic [11:0] start_wp);
      logic [11:0] exp_addr;
      logic [11:0] last_addr;
      logic [11:0] end_wp;
      logic [7:0]  eb;
      bus.out_ready   = 1'b1;
      bus.in_valid    = 1'b1;
      bus.in_is_copy  = v.is_copy;
      bus.in_literal  = v.lit;
      bus.in_offset   = v.off;
      bus.in_len_code = v.len_code;
      #1;
      chk("accept_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clock);
      bus.in_valid = 1'b0;
      last_addr = start_wp;
      for (int k = 0; k < v.n; k++) begin
         eb = v.pat[(k % 8) * 8 +: 8];
         exp_addr = start_wp + k[11:0];
         chk("out_valid",  {31'd0, bus.out_valid}, 32'd1);
         chk("busy",       {31'd0, busy}, 32'd1);
         chk("in_ready_lo", {31'd0, bus.in_ready}, 32'd0);
         chk("out_data",   {24'd0, bus.out_data}, {24'd0, eb});
         chk("hb_wr_en",   {31'd0, bus.hb_wr_en}, 32'd1);
         chk("hb_wr_addr", {20'd0, bus.hb_wr_addr}, {20'd0, exp_addr});
         chk("hb_data_in", {24'd0, bus.hb_data_in}, {24'd0, eb});
         last_addr = bus.hb_wr_addr;
         @(negedge clock);
      end
      chk_idle("gap");
      end_wp = last_addr + 12'd1;
      chk("wp_end", {20'd0, end_wp}, {20'd0, v.wp_end});
   endtask

   function automatic vec_t mk_lit(input logic [7:0] lit, input logic [11:0] wp_end);
      mk_lit = '{1'b0, 0, 1'b0, lit, 12'd0, 4'd0, 1, {56'd0, lit}, wp_end};
   endfunction

   logic [11:0] cur_wp;
   logic [7:0]  bp_exp [5];
   logic [15:0] rdy_pat;
   int          idx;
   int          writes;

   initial begin
      clock = 1'b0;
      reset = 1'b1;
      bus.in_valid    = 1'b0;
      bus.in_is_copy  = 1'b0;
      bus.in_literal  = 8'h00;
      bus.in_offset   = 12'd0;
      bus.in_len_code = 4'd0;
      bus.out_ready   = 1'b1;
      for (int i = 0; i < 4096; i++) mem[i] = i[7:0] ^ 8'hA5;

      vecs[0]  = '{1'b1, 0,    1'b0, 8'h41, 12'd0, 4'd0,  1,  64'h41, 12'd1};
      vecs[1]  = '{1'b0, 0,    1'b0, 8'h42, 12'd0, 4'd0,  1,  64'h42, 12'd2};
      vecs[2]  = '{1'b0, 0,    1'b0, 8'h43, 12'd0, 4'd0,  1,  64'h43, 12'd3};
      vecs[3]  = '{1'b1, 0,    1'b0, 8'h41, 12'd0, 4'd0,  1,  64'h41, 12'd1};
      vecs[4]  = '{1'b0, 0,    1'b0, 8'h42, 12'd0, 4'd0,  1,  64'h42, 12'd2};
      vecs[5]  = '{1'b0, 0,    1'b1, 8'h00, 12'd2, 4'd1,  4,  64'h42414241, 12'd6};
      vecs[6]  = '{1'b1, 0,    1'b0, 8'h55, 12'd0, 4'd0,  1,  64'h55, 12'd1};
      vecs[7]  = '{1'b0, 0,    1'b1, 8'h00, 12'd1, 4'd15, 18, 64'h5555555555555555, 12'd19};
      vecs[8]  = '{1'b0, 0,    1'b1, 8'h00, 12'd0, 4'd0,  3,  64'hB0B1B6, 12'd22};
      vecs[9]  = '{1'b1, 4094, 1'b0, 8'h58, 12'd0, 4'd0,  1,  64'h58, 12'd4095};
      vecs[10] = '{1'b0, 0,    1'b0, 8'h59, 12'd0, 4'd0,  1,  64'h59, 12'd0};
      vecs[11] = '{1'b0, 0,    1'b1, 8'h00, 12'd3, 4'd0,  3,  64'h5958FD, 12'd3};

      @(negedge clock);
      cur_wp = 12'd0;
      for (int v = 0; v < 12; v++) begin
         if (vecs[v].rst) begin
            do_reset();
            cur_wp = 12'd0;
         end
         for (int i = 0; i < vecs[v].pre; i++) send_quiet(i[7:0]);
         if (vecs[v].pre > 0) cur_wp = vecs[v].pre[11:0];
         run_item(vecs[v], cur_wp);
         cur_wp = vecs[v].wp_end;
      end

      // Backpressure during a length-5 overlapping copy.
      do_reset();
      run_item(mk_lit(8'h11, 12'd1), 12'd0);
      run_item(mk_lit(8'h22, 12'd2), 12'd1);
      run_item(mk_lit(8'h33, 12'd3), 12'd2);
      bp_exp[0] = 8'h11; bp_exp[1] = 8'h22; bp_exp[2] = 8'h33;
      bp_exp[3] = 8'h11; bp_exp[4] = 8'h22;
      rdy_pat = 16'b1001_0110_1001_1111;
      bus.in_valid    = 1'b1;
      bus.in_is_copy  = 1'b1;
      bus.in_offset   = 12'd3;
      bus.in_len_code = 4'd2;
      #1;
      chk("bp_accept", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clock);
      bus.in_valid = 1'b0;
      idx = 0;
      writes = 0;
      for (int cyc = 0; cyc < 30 && idx < 5; cyc++) begin
         bus.out_ready = rdy_pat[15 - (cyc % 16)];
         #1;
         chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp_out_data", {24'd0, bus.out_data}, {24'd0, bp_exp[idx]});
         chk("bp_wr_en", {31'd0, bus.hb_wr_en}, {31'd0, bus.out_ready});
         if (bus.hb_wr_en) writes++;
         if (bus.out_ready) begin
            chk("bp_wr_addr", {20'd0, bus.hb_wr_addr}, 32'd3 + idx);
            idx++;
         end
         @(negedge clock);
      end
      chk("bp_done", idx, 5);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (bus.hb_wr_en) writes++;
         chk_idle("bp_after");
         @(negedge clock);
      end
      chk("bp_writes", writes, 5);
      chk("bp_mem7", {24'd0, mem[7]}, 32'h22);

      // Reset on the third byte of a copy abandons the item.
      do_reset();
      run_item(mk_lit(8'h77, 12'd1), 12'd0);
      bus.in_valid    = 1'b1;
      bus.in_is_copy  = 1'b1;
      bus.in_offset   = 12'd1;
      bus.in_len_code = 4'd2;
      @(negedge clock);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("rc_wr_en", {31'd0, bus.hb_wr_en}, 32'd1);
         chk("rc_data", {24'd0, bus.out_data}, 32'h77);
         @(negedge clock);
      end
      chk("rc_third_valid", {31'd0, bus.out_valid}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rc_async_wr_en", {31'd0, bus.hb_wr_en}, 32'd0);
      @(negedge clock);
      chk_idle("rc_next");
      chk("rc_mem3", {24'd0, mem[3]}, 32'h11);
      reset = 1'b0;
      @(negedge clock);
      run_item(mk_lit(8'h99, 12'd1), 12'd0);
      chk("rc_mem0", {24'd0, mem[0]}, 32'h99);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/copy_expander.md
COPY_EXPANDER -- requirements
Module: copy_expander

Interface
REQ-001 Parameter HISTORY_SIZE, default 4096, depth of the external history buffer in bytes.
REQ-002 Localparam HISTORY_ADDR_WIDTH = $clog2(HISTORY_SIZE), which is 12 at the default.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  an item is presented on the in_* fields.
REQ-007 in_ready  output  1  expander accepts an item this cycle.
REQ-008 in_is_copy  input  1  1 = copy item, 0 = literal item.
REQ-009 in_literal  input  8  literal byte; used only when in_is_copy = 0.
REQ-010 in_offset  input  HISTORY_ADDR_WIDTH  copy distance back from the write pointer; used only for copy items.
REQ-011 in_len_code  input  4  copy length minus 3, so lengths run 3..18; used only for copy items.
REQ-012 out_valid  output  1  out_data holds a decompressed byte.
REQ-013 out_ready  input  1  the downstream consumer accepts out_data.
REQ-014 out_data  output  8  decompressed byte.
REQ-015 hb_wr_en, hb_wr_addr, hb_data_in  output  1 / HISTORY_ADDR_WIDTH / 8  history buffer write port.
REQ-016 hb_rd_addr  output  HISTORY_ADDR_WIDTH  history buffer read address.
REQ-017 hb_data_out  input  8  combinational read data for hb_rd_addr; a write becomes readable on the cycle after it.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 The state machine SHALL have three states: IDLE, LIT and COPY.
REQ-020 in_ready SHALL equal (state == IDLE).
REQ-021 An item is accepted when in_valid and in_ready are both high.
REQ-022 Accepting a literal item SHALL capture in_literal into lit_reg and move the state to LIT.
REQ-023 Accepting a copy item SHALL do all of the following on the same edge:
  - set rd_ptr = (wp - in_offset) mod HISTORY_SIZE;
  - set remaining = in_len_code + 3;
  - move the state to COPY.
REQ-024 In_offset = 0 SHALL be treated as distance HISTORY_SIZE, so rd_ptr = wp; this is not an error.
REQ-025 out_valid SHALL equal (state == LIT or state == COPY).
REQ-026 out_data SHALL be lit_reg in LIT and hb_data_out in COPY.
REQ-027 hb_rd_addr SHALL equal rd_ptr.
REQ-028 A transfer occurs when out_valid and out_ready are both high.
REQ-029 On each transfer, in the same cycle:
  - hb_wr_en SHALL be 1, hb_wr_addr SHALL be wp, and hb_data_in SHALL be out_data;
  - wp SHALL increment mod HISTORY_SIZE on the next edge.
REQ-030 hb_wr_en SHALL be 0 whenever no transfer occurs.
REQ-031 In LIT, a transfer SHALL move the state to IDLE.
REQ-032 In COPY, a transfer SHALL increment rd_ptr mod HISTORY_SIZE and decrement remaining.
REQ-033 In COPY, the state SHALL return to IDLE on the transfer made while remaining == 1.
REQ-034 While out_ready = 0, every state and pointer SHALL hold, and out_data SHALL remain stable.
REQ-035 Latency: an item accepted on edge n SHALL have its first byte valid in the cycle after edge n.
REQ-036 Throughput SHALL be one byte per cycle within an item.
REQ-037 There SHALL be exactly one IDLE cycle between consecutive items.
REQ-038 Overlapping copies (offset < length) SHALL replicate bytes correctly, using the one-cycle write-to-read visibility of REQ-017.
REQ-039 Pointer arithmetic SHALL be HISTORY_ADDR_WIDTH bits wide with silent wrap, at both HISTORY_SIZE-1 -> 0 and subtraction underflow.

Reset
REQ-040 While reset is high, and immediately after it is released, the outputs SHALL be:
  - state = IDLE, wp = 0, rd_ptr = 0, remaining = 0, lit_reg = 0;
  - out_valid = 0, hb_wr_en = 0, busy = 0;
  - in_ready = 1.
REQ-041 Reset asserted in the middle of an item SHALL abandon that item with no further hb writes.
REQ-042 History buffer contents SHALL NOT be cleared by this block.

Verification
REQ-043 Literals 0x41, 0x42, 0x43 with out_ready = 1 SHALL produce:
  - out_data sequence 41, 42, 43;
  - hb writes at addresses 0, 1, 2;
  - one bubble between bytes.
REQ-044 Literals A, B, then copy offset 2, len_code 1 (length 4) SHALL produce output A B A B A B and final wp = 6.
REQ-045 Literal 0x55, then copy offset 1, len_code 15 SHALL produce 19 bytes of 0x55 in total, with wp ending at 19.
REQ-046 With wp preloaded to 4094 via 4094 literals, then literal X, literal Y and a copy with offset 3, len_code 0, SHALL:
  - write X at address 4094 and Y at address 4095;
  - copy from rd_ptr 4093, wrapping to 0;
  - leave wp = 3.
REQ-047 Toggling out_ready (1,0,0,1,...) during a length-5 copy SHALL produce exactly five hb writes, with out_data held stable while out_ready is low.
REQ-048 Asserting reset on the third byte of a copy SHALL give, on the next cycle:
  - out_valid = 0, in_ready = 1, hb_wr_en = 0;
  - a subsequent literal written at address 0.
